// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: transmit FSM state encodings
// and the default bit period for a 50 MHz clock at 115200 baud.
package uart_tx_buffered_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_byte_fifo.sv
// Byte FIFO with registered read data; RDATA is valid
// the cycle after RD. Writes while full are dropped.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR,
  input  logic [7:0]    WDATA,
  input  logic          RD,
  output logic [7:0]    RDATA,
  output logic [AW:0]   COUNT,
  output logic          FULL,
  output logic          EMPTY
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign FULL  = (COUNT == DEPTH);
  assign EMPTY = (COUNT == '0);
  assign do_wr = WR && !FULL;
  assign do_rd = RD && !EMPTY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
      RDATA <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr  <= rptr + 1'b1;
        RDATA <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wptr] <= WDATA;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an
// LSB-first serialiser with a registered TXD.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_AW      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DATA,
  input  logic       DATA_READY,
  output logic       FULL,
  output logic       IDLE,
  output logic       OVERFLOW,
  output logic       TXD
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q;
  logic             load_q;
  logic             ovf_q;
  logic             txd_q;
  logic             pop;
  logic             baud_last;
  logic [7:0]       rdata;
  logic [FIFO_AW:0] count;
  logic             fifo_full;
  logic             fifo_empty;

  byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .WR    (DATA_READY),
    .WDATA (DATA),
    .RD    (pop),
    .RDATA (rdata),
    .COUNT (count),
    .FULL  (fifo_full),
    .EMPTY (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign FULL      = fifo_full;
  assign IDLE      = (state_q == S_IDLE) && (count == '0);
  assign OVERFLOW  = ovf_q;
  assign TXD       = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  // shift register loads one cycle after the pop (read latency)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      ovf_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      load_q  <= pop;
      if (load_q) begin
        shift_q <= rdata;
      end else if (state_q == S_DATA && baud_last) begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
      if (DATA_READY && fifo_full) ovf_q <= 1'b1;
      unique case (state_q)
        S_START: txd_q <= 1'b0;
        S_DATA:  txd_q <= shift_q[0];
        default: txd_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with a serial
// receiver model decoding TXD at CLKS_PER_BIT=4.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
  localparam int AW  = 2;

  logic       CLK;
  logic       RST;
  logic [7:0] DATA;
  logic       DATA_READY;
  logic       FULL;
  logic       IDLE;
  logic       OVERFLOW;
  logic       TXD;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA       (DATA),
    .DATA_READY (DATA_READY),
    .FULL       (FULL),
    .IDLE       (IDLE),
    .OVERFLOW   (OVERFLOW),
    .TXD        (TXD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // receiver: samples mid-bit on falling edges
  initial begin : rx_model
    int         st;
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge CLK);
      if (TXD === 1'b0 && RST === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge CLK);
        ok = (TXD === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          b[i] = TXD;
        end
        repeat (CPB) @(negedge CLK);
        if (ok && TXD === 1'b1) begin
          rx_q.push_back(b);
          rx_t.push_back(st);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    DATA_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (IDLE !== 1'b1 && n < lim) begin
      @(negedge CLK);
      n++;
    end
    nvec++;
    if (IDLE !== 1'b1) begin
      nmis++;
      $display("FAIL idle_timeout got IDLE=%b want 1", IDLE);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_rx(input string nm, input logic [7:0] exp[$]);
    logic [7:0] got;
    nvec++;
    if (rx_q.size() != exp.size()) begin
      nmis++;
      $display("FAIL %s_count got %0d want %0d", nm, rx_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      nvec++;
      if (got !== exp[i]) begin
        nmis++;
        $display("FAIL %s_byte%0d got %h want %h", nm, i, got, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    DATA_READY = 1'b0;
    DATA = 8'h00;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    nvec++;
    if (TXD !== 1'b1) begin
      nmis++; $display("FAIL rst_txd got %b want 1", TXD);
    end
    nvec++;
    if (FULL !== 1'b0) begin
      nmis++; $display("FAIL rst_full got %b want 0", FULL);
    end
    nvec++;
    if (IDLE !== 1'b1) begin
      nmis++; $display("FAIL rst_idle got %b want 1", IDLE);
    end
    nvec++;
    if (OVERFLOW !== 1'b0) begin
      nmis++; $display("FAIL rst_ovf got %b want 0", OVERFLOW);
    end
  endtask

  task automatic test_single();
    logic [7:0] b;
    logic       e;
    logic [7:0] exp[$];
    do_reset();
    b = 8'h55;
    DATA = b;
    DATA_READY = 1'b1;
    @(negedge CLK);
    DATA_READY = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge CLK);
      if (k < 2)       e = 1'b1;
      else if (k < 6)  e = 1'b0;
      else if (k < 38) e = b[(k - 6) / 4];
      else             e = 1'b1;
      nvec++;
      if (TXD !== e) begin
        nmis++; $display("FAIL single_txd_k%0d got %b want %b", k, TXD, e);
      end
      if (k == 20) begin
        nvec++;
        if (IDLE !== 1'b0) begin
          nmis++; $display("FAIL single_busy got %b want 0", IDLE);
        end
      end
      if (k == 42) begin
        nvec++;
        if (IDLE !== 1'b1) begin
          nmis++; $display("FAIL single_idle got %b want 1", IDLE);
        end
      end
    end
    exp = '{8'h55};
    check_rx("single", exp);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int         gap;
    do_reset();
    DATA = 8'hA5;
    DATA_READY = 1'b1;
    @(negedge CLK);
    DATA = 8'h3C;
    @(negedge CLK);
    DATA_READY = 1'b0;
    wait_idle(200);
    exp = '{8'hA5, 8'h3C};
    check_rx("b2b", exp);
    gap = (rx_t.size() == 2) ? rx_t[1] - rx_t[0] : -1;
    nvec++;
    if (gap != 10 * CPB) begin
      nmis++; $display("FAIL b2b_gap got %0d want %0d", gap, 10 * CPB);
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp[$];
    do_reset();
    DATA_READY = 1'b1;
    DATA = 8'h10;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      if (i == 4) begin
        nvec++;
        if (FULL !== 1'b0) begin
          nmis++; $display("FAIL fill_notfull got %b want 0", FULL);
        end
      end
      DATA = 8'(8'h10 + i);
    end
    @(negedge CLK);
    nvec++;
    if (FULL !== 1'b1) begin
      nmis++; $display("FAIL fill_full got %b want 1", FULL);
    end
    DATA = 8'hEE;
    @(negedge CLK);
    DATA_READY = 1'b0;
    nvec++;
    if (OVERFLOW !== 1'b1) begin
      nmis++; $display("FAIL fill_ovf got %b want 1", OVERFLOW);
    end
    repeat (35) @(negedge CLK);
    nvec++;
    if (FULL !== 1'b1) begin
      nmis++; $display("FAIL pop_prefull got %b want 1", FULL);
    end
    DATA = 8'hDD;
    DATA_READY = 1'b1;
    @(negedge CLK);
    nvec++;
    if (FULL !== 1'b0) begin
      nmis++; $display("FAIL pop_full got %b want 0", FULL);
    end
    DATA = 8'h77;
    @(negedge CLK);
    DATA_READY = 1'b0;
    nvec++;
    if (FULL !== 1'b1) begin
      nmis++; $display("FAIL pop_refull got %b want 1", FULL);
    end
    wait_idle(400);
    nvec++;
    if (OVERFLOW !== 1'b1) begin
      nmis++; $display("FAIL pop_ovf got %b want 1", OVERFLOW);
    end
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h77};
    check_rx("fill", exp);
  endtask

  task automatic test_reset_midframe();
    int bad;
    do_reset();
    DATA_READY = 1'b1;
    DATA = 8'hFF;
    @(negedge CLK);
    DATA = 8'h11;
    @(negedge CLK);
    DATA = 8'h22;
    @(negedge CLK);
    DATA_READY = 1'b0;
    repeat (17) @(negedge CLK);
    RST = 1'b1;
    DATA_READY = 1'b1;
    DATA = 8'h99;
    @(negedge CLK);
    RST = 1'b0;
    DATA_READY = 1'b0;
    nvec++;
    if (TXD !== 1'b1) begin
      nmis++; $display("FAIL mid_txd got %b want 1", TXD);
    end
    nvec++;
    if (IDLE !== 1'b1) begin
      nmis++; $display("FAIL mid_idle got %b want 1", IDLE);
    end
    nvec++;
    if (FULL !== 1'b0) begin
      nmis++; $display("FAIL mid_full got %b want 0", FULL);
    end
    nvec++;
    if (OVERFLOW !== 1'b0) begin
      nmis++; $display("FAIL mid_ovf got %b want 0", OVERFLOW);
    end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (TXD !== 1'b1 || IDLE !== 1'b1) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nmis++; $display("FAIL mid_quiet got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    int         idx;
    int         guard;
    do_reset();
    idx = 0;
    guard = 0;
    while (idx < 20 && guard < 2000) begin
      if (FULL === 1'b0) begin
        DATA = 8'(idx);
        DATA_READY = 1'b1;
        idx++;
      end else begin
        DATA_READY = 1'b0;
      end
      @(negedge CLK);
      guard++;
    end
    DATA_READY = 1'b0;
    nvec++;
    if (idx != 20) begin
      nmis++; $display("FAIL wrap_feed got %0d want 20", idx);
    end
    wait_idle(1500);
    nvec++;
    if (OVERFLOW !== 1'b0) begin
      nmis++; $display("FAIL wrap_ovf got %b want 0", OVERFLOW);
    end
    exp.delete();
    for (int i = 0; i < 20; i++) exp.push_back(8'(i));
    check_rx("wrap", exp);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_reset_midframe();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
